// File: rtl/wb_stage_reg.sv
// MEM->WB pipeline register: carries per-lane register writes and one merged
// HI/LO write into write-back, resolves same-bundle conflicts, counts retirements.
module wb_stage_reg #(
  parameter int LANES   = 2,
  parameter int DATA_W  = 32,
  parameter int RA_W    = 5,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int RCNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic [LANES-1:0]         mem_valid,
  input  logic [LANES-1:0]         mem_wreg,
  input  logic [LANES*RA_W-1:0]    mem_wd,
  input  logic [LANES*DATA_W-1:0]  mem_wdata,
  input  logic [LANES-1:0]         mem_whilo,
  input  logic [LANES*DATA_W-1:0]  mem_hi,
  input  logic [LANES*DATA_W-1:0]  mem_lo,
  output logic [LANES-1:0]         wb_valid,
  output logic [LANES-1:0]         wb_wreg,
  output logic [LANES*RA_W-1:0]    wb_wd,
  output logic [LANES*DATA_W-1:0]  wb_wdata,
  output logic                     wb_whilo,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
  output logic [RCNT_W-1:0]        retire_cnt
);

  localparam int PC_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } act_t;

  act_t                    act_s;
  logic [LANES-1:0]        eff_s;
  logic [LANES-1:0]        wreg_s;
  logic                    hilo_s;
  logic [DATA_W-1:0]       hi_s;
  logic [DATA_W-1:0]       lo_s;
  logic [PC_W-1:0]         pop_s;

  logic [LANES-1:0]        wb_valid_r;
  logic [LANES-1:0]        wb_wreg_r;
  logic [LANES*RA_W-1:0]   wb_wd_r;
  logic [LANES*DATA_W-1:0] wb_wdata_r;
  logic                    wb_whilo_r;
  logic [DATA_W-1:0]       wb_hi_r;
  logic [DATA_W-1:0]       wb_lo_r;
  logic [RCNT_W-1:0]       retire_cnt_r;

  // Decide this edge's action; flush wins over any stall combination
  always_comb begin
    act_s = ACT_HOLD;
    if (flush) begin
      act_s = ACT_BUBBLE;
    end else if (!stall[STAGE]) begin
      act_s = ACT_LOAD;
    end else if (!stall[STAGE+1]) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_HOLD;
    end
  end

  // Same-destination writes inside a bundle: a higher lane masks every lower one
  always_comb begin
    eff_s  = mem_wreg & mem_valid;
    wreg_s = eff_s;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        wreg_s[i] = wreg_s[i] &
                    ~(eff_s[j] & (mem_wd[i*RA_W +: RA_W] == mem_wd[j*RA_W +: RA_W]));
      end
    end
  end

  // HI/LO merge (ascending scan so the highest writing lane is kept) and valid popcount
  always_comb begin
    hilo_s = 1'b0;
    hi_s   = {DATA_W{1'b0}};
    lo_s   = {DATA_W{1'b0}};
    pop_s  = {PC_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      pop_s = pop_s + PC_W'(mem_valid[i]);
      if (mem_whilo[i] & mem_valid[i]) begin
        hilo_s = 1'b1;
        hi_s   = mem_hi[i*DATA_W +: DATA_W];
        lo_s   = mem_lo[i*DATA_W +: DATA_W];
      end else begin
        hilo_s = hilo_s;
      end
    end
  end

  // Pipeline register and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r   <= {LANES{1'b0}};
      wb_wreg_r    <= {LANES{1'b0}};
      wb_wd_r      <= {(LANES*RA_W){1'b0}};
      wb_wdata_r   <= {(LANES*DATA_W){1'b0}};
      wb_whilo_r   <= 1'b0;
      wb_hi_r      <= {DATA_W{1'b0}};
      wb_lo_r      <= {DATA_W{1'b0}};
      retire_cnt_r <= {RCNT_W{1'b0}};
    end else begin
      case (act_s)
        ACT_LOAD: begin
          wb_valid_r   <= mem_valid;
          wb_wreg_r    <= wreg_s;
          wb_wd_r      <= mem_wd;
          wb_wdata_r   <= mem_wdata;
          wb_whilo_r   <= hilo_s;
          wb_hi_r      <= hi_s;
          wb_lo_r      <= lo_s;
          retire_cnt_r <= retire_cnt_r + RCNT_W'(pop_s);
        end
        ACT_BUBBLE: begin
          wb_valid_r   <= {LANES{1'b0}};
          wb_wreg_r    <= {LANES{1'b0}};
          wb_wd_r      <= {(LANES*RA_W){1'b0}};
          wb_wdata_r   <= {(LANES*DATA_W){1'b0}};
          wb_whilo_r   <= 1'b0;
          wb_hi_r      <= {DATA_W{1'b0}};
          wb_lo_r      <= {DATA_W{1'b0}};
          retire_cnt_r <= retire_cnt_r;
        end
        default: begin
          retire_cnt_r <= retire_cnt_r;
        end
      endcase
    end
  end

  assign wb_valid   = wb_valid_r;
  assign wb_wreg    = wb_wreg_r;
  assign wb_wd      = wb_wd_r;
  assign wb_wdata   = wb_wdata_r;
  assign wb_whilo   = wb_whilo_r;
  assign wb_hi      = wb_hi_r;
  assign wb_lo      = wb_lo_r;
  assign retire_cnt = retire_cnt_r;

endmodule
